// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write path.
// Register/data widths and the queued write-entry format.
package mips_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  localparam logic [DEF_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEF_AW-1:0] rd;
    logic [DEF_DW-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/reg_write_queue_fifo.sv
// Circular buffer of pending register writes.
// Two write ports (wr0 lands before wr1), one read port at the head.
module reg_write_queue_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_en,
  input  wq_entry_t     wr0,
  input  logic          wr1_en,
  input  wq_entry_t     wr1,
  input  logic          rd_en,
  output wq_entry_t     head,
  output wq_entry_t     slots [DEPTH],
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          margin_low
);

  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_nx;
  logic [1:0]    n_enq;
  logic          deq;

  assign deq   = rd_en && (count != '0);
  assign n_enq = {1'b0, wr0_en} + {1'b0, wr1_en};

  assign count_nx = count + CW'(n_enq) - CW'(deq);

  // Fewer than two free slots left once this cycle's update lands.
  assign margin_low = count_nx > CW'(DEPTH - 2);

  assign head = slots[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (wr0_en) begin
        slots[wr_ptr] <= wr0;
      end
      if (wr1_en) begin
        slots[wr_ptr + PW'(wr0_en)] <= wr1;
      end
      wr_ptr <= wr_ptr + PW'(n_enq);
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nx;
    end
  end

endmodule

// File: rtl/reg_write_queue.sv
// Merges load and ALU writebacks onto the single reg_file write port.
// In-order queue with empty-queue bypass and forwarding of pending writes.
module reg_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          stall,
  output logic          overflow,
  output logic          we,
  output logic [AW-1:0] reg_w,
  output logic [DW-1:0] bus_w,
  input  logic [AW-1:0] q_reg_a,
  input  logic [AW-1:0] q_reg_b,
  output logic          fwd_hit_a,
  output logic [DW-1:0] fwd_data_a,
  output logic          fwd_hit_b,
  output logic [DW-1:0] fwd_data_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wq_entry_t     e_m;
  wq_entry_t     e_a;
  wq_entry_t     head;
  wq_entry_t     wr0;
  wq_entry_t     wr1;
  wq_entry_t     out_nx;
  wq_entry_t     slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          margin_low;
  logic          empty;
  logic          take_m;
  logic          take_a;
  logic          wr0_en;
  logic          wr1_en;
  logic          out_nx_we;

  assign e_m = '{rd: mem_rd, data: mem_data};
  assign e_a = '{rd: alu_rd, data: alu_data};

  assign take_m = mem_we && (mem_rd != REG_ZERO) && !stall;
  assign take_a = alu_we && (alu_rd != REG_ZERO) && !stall;
  assign empty  = (count == '0);

  // Head drains first; with an empty queue the oldest new request bypasses.
  always_comb begin
    out_nx_we = 1'b0;
    out_nx    = head;
    wr0_en    = 1'b0;
    wr0       = e_m;
    wr1_en    = 1'b0;
    wr1       = e_a;
    if (!empty) begin
      out_nx_we = 1'b1;
      wr0_en    = take_m | take_a;
      wr0       = take_m ? e_m : e_a;
      wr1_en    = take_m & take_a;
    end else if (take_m) begin
      out_nx_we = 1'b1;
      out_nx    = e_m;
      wr0_en    = take_a;
      wr0       = e_a;
    end else if (take_a) begin
      out_nx_we = 1'b1;
      out_nx    = e_a;
    end
  end

  reg_write_queue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr0_en    (wr0_en),
    .wr0       (wr0),
    .wr1_en    (wr1_en),
    .wr1       (wr1),
    .rd_en     (!empty),
    .head      (head),
    .slots     (slots),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .margin_low(margin_low)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we       <= 1'b0;
      reg_w    <= '0;
      bus_w    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      we <= out_nx_we;
      if (out_nx_we) begin
        reg_w <= out_nx.rd;
        bus_w <= out_nx.data;
      end
      stall    <= margin_low;
      overflow <= overflow | (stall & (mem_we | alu_we));
    end
  end

  // Walk oldest to youngest so the youngest match is left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    if (we && reg_w == q_reg_a) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = bus_w;
    end
    if (we && reg_w == q_reg_b) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = bus_w;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (slots[idx].rd == q_reg_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = slots[idx].data;
        end
        if (slots[idx].rd == q_reg_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = slots[idx].data;
        end
      end
    end
    if (q_reg_a == REG_ZERO) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
    if (q_reg_b == REG_ZERO) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
// Bench for reg_write_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_reg_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        stall;
  logic        overflow;
  logic        we;
  logic [4:0]  reg_w;
  logic [31:0] bus_w;
  logic [4:0]  q_reg_a = '0;
  logic [4:0]  q_reg_b = '0;
  logic        fwd_hit_a;
  logic [31:0] fwd_data_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .alu_we    (alu_we),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .stall     (stall),
    .overflow  (overflow),
    .we        (we),
    .reg_w     (reg_w),
    .bus_w     (bus_w),
    .q_reg_a   (q_reg_a),
    .q_reg_b   (q_reg_b),
    .fwd_hit_a (fwd_hit_a),
    .fwd_data_a(fwd_data_a),
    .fwd_hit_b (fwd_hit_b),
    .fwd_data_b(fwd_data_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of accepted-but-unwritten writes plus the
  // write currently on the reg_file port.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_stall;
  logic        m_ovf;

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_rd = '0;
    m_data = '0;
    m_stall = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic mwe, input logic [4:0] mrd,
                            input logic [31:0] md, input logic awe,
                            input logic [4:0] ard, input logic [31:0] ad);
    ent_t e;
    if (m_stall) begin
      if (mwe || awe) m_ovf = 1'b1;
    end else begin
      if (mwe && mrd != 0) mq.push_back('{rd: mrd, data: md});
      if (awe && ard != 0) mq.push_back('{rd: ard, data: ad});
    end
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1;
      m_rd = e.rd;
      m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    m_stall = (mq.size() > DEPTH - 2);
  endtask

  task automatic model_fwd(input logic [4:0] q, output logic hit,
                           output logic [31:0] d);
    hit = 1'b0;
    d = '0;
    if (q != 0) begin
      if (m_we && m_rd == q) begin
        hit = 1'b1;
        d = m_data;
      end
      foreach (mq[i]) begin
        if (mq[i].rd == q) begin
          hit = 1'b1;
          d = mq[i].data;
        end
      end
    end
  endtask

  task automatic cycle(input logic mwe, input logic [4:0] mrd,
                       input logic [31:0] md, input logic awe,
                       input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] qa, input logic [4:0] qb);
    logic        eh;
    logic [31:0] ed;
    mem_we = mwe; mem_rd = mrd; mem_data = md;
    alu_we = awe; alu_rd = ard; alu_data = ad;
    q_reg_a = qa; q_reg_b = qb;
    #1;
    model_fwd(qa, eh, ed);
    chk("fwd_hit_a", 64'(fwd_hit_a), 64'(eh));
    chk("fwd_data_a", 64'(fwd_data_a), 64'(ed));
    model_fwd(qb, eh, ed);
    chk("fwd_hit_b", 64'(fwd_hit_b), 64'(eh));
    chk("fwd_data_b", 64'(fwd_data_b), 64'(ed));
    model_step(mwe, mrd, md, awe, ard, ad);
    @(posedge clk);
    #1;
    chk("we", 64'(we), 64'(m_we));
    if (m_we) begin
      chk("reg_w", 64'(reg_w), 64'(m_rd));
      chk("bus_w", 64'(bus_w), 64'(m_data));
    end
    chk("stall", 64'(stall), 64'(m_stall));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, qb);
  endtask

  task automatic do_reset();
    mem_we = 1'b0;
    alu_we = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        awe;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic [4:0]  qa;
    logic        ewe;
    logic [4:0]  erw;
    logic [31:0] ebw;
    logic        ehit;
    logic [31:0] efwd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int saw_stall;
    int k;
    tbl[0]  = '{1, 3, 32'hA5A5_0001, 0, 0, 0, 3, 1, 3, 32'hA5A5_0001, 1, 32'hA5A5_0001};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 7, 1, 1, 7, 2, 7, 1, 7, 1, 1, 2};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 7, 1, 7, 2, 1, 2};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 5, 32'h55, 1, 9, 32'h99, 5, 1, 5, 32'h55, 1, 32'h55};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 9, 1, 9, 32'h99, 1, 32'h99};
    tbl[9]  = '{0, 0, 0, 1, 12, 32'hC, 12, 1, 12, 32'hC, 1, 32'hC};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0};

    #2;
    chk("init_we", 64'(we), 64'd0);
    chk("init_fwd_a", 64'(fwd_hit_a), 64'd0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      mem_we = tbl[i].mwe; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
      alu_we = tbl[i].awe; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      q_reg_a = tbl[i].qa;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 64'(we), 64'(tbl[i].ewe));
      if (tbl[i].ewe) begin
        chk($sformatf("v%0d_reg_w", i), 64'(reg_w), 64'(tbl[i].erw));
        chk($sformatf("v%0d_bus_w", i), 64'(bus_w), 64'(tbl[i].ebw));
      end
      chk($sformatf("v%0d_hit_a", i), 64'(fwd_hit_a), 64'(tbl[i].ehit));
      chk($sformatf("v%0d_fwd_a", i), 64'(fwd_data_a), 64'(tbl[i].efwd));
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'd0);
    end

    do_reset();
    saw_stall = 0;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (!m_stall) begin
        cycle(1'b1, 5'(1 + k % 30), 32'h100 + 32'(k), 1'b1,
              5'(1 + (k + 1) % 30), 32'h100 + 32'(k + 1), 5'(1 + k % 30), 5'd0);
        k = k + 2;
      end else begin
        idle(5'(1 + k % 30), 5'(k % 30));
      end
      if (stall) saw_stall++;
    end
    chk("stall_rose", 64'(saw_stall > 0), 64'd1);
    for (int c = 0; c < 6; c++) idle(5'd1, 5'd2);
    chk("no_overflow", 64'(overflow), 64'd0);

    for (int c = 0; c < 8 && !m_stall; c++) begin
      cycle(1'b1, 5'd20 + 5'(c), 32'h200 + 32'(c), 1'b1, 5'd24 + 5'(c),
            32'h300 + 32'(c), 5'd20, 5'd24);
    end
    chk("stall_before_ovf", 64'(stall), 64'd1);
    cycle(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd31, 5'd20);
    for (int c = 0; c < 6; c++) idle(5'd31, 5'd24);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    do_reset();
    cycle(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2, 5'd10, 5'd11);
    cycle(1'b1, 5'd12, 32'h3, 1'b1, 5'd13, 32'h4, 5'd12, 5'd13);
    q_reg_a = 5'd12;
    q_reg_b = 5'd13;
    #1;
    chk("pre_rst_hit_a", 64'(fwd_hit_a), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_we", 64'(we), 64'd0);
    chk("async_rst_hit_a", 64'(fwd_hit_a), 64'd0);
    chk("async_rst_hit_b", 64'(fwd_hit_b), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) idle(5'd12, 5'd13);

    for (int c = 0; c < 400; c++) begin
      logic        mwe;
      logic        awe;
      logic [4:0]  mrd;
      logic [4:0]  ard;
      mwe = ($urandom_range(0, 2) != 0);
      awe = ($urandom_range(0, 2) != 0);
      if (m_stall && $urandom_range(0, 15) != 0) begin
        mwe = 1'b0;
        awe = 1'b0;
      end
      mrd = 5'($urandom_range(0, 7));
      ard = 5'($urandom_range(0, 7));
      cycle(mwe, mrd, $urandom, awe, ard, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
